// File: rtl/spio_hss_tx_frame_mux_pkg.sv
// Shared constants for the HSS TX framer: K-characters, fixed IDLE/CC words,
// K-flag patterns, framer state encoding and the CRC-16-CCITT word update.
package spio_hss_tx_frame_mux_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K23_7 = 8'hF7;

  localparam logic [31:0] IdleWord = {K28_5, 24'h50_5050};
  localparam logic [31:0] CcWord   = {4{K23_7}};

  // K flags, bit 3 covers byte 31:24
  localparam logic [3:0] IdleK = 4'b1000;
  localparam logic [3:0] CcK   = 4'b1111;
  localparam logic [3:0] HdrK  = 4'b1000;
  localparam logic [3:0] DataK = 4'b0000;

  // State names the word currently held on TXDATA_OUT
  typedef enum logic [2:0] {
    StIdle,
    StCc,
    StHdr,
    StData,
    StTrl
  } tx_state_e;

  // CRC-16-CCITT (poly 0x1021), one 32-bit word folded in MSB first
  function automatic logic [15:0] crc16_word(logic [15:0] crc_in, logic [31:0] data);
    logic [15:0] crc;
    crc = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (crc[15] ^ data[i]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
      else                   crc = {crc[14:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/spio_hss_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap, returns a
// one-hot grant plus its index; the pointer moves past the winner on advance.
module spio_hss_rr_arbiter #(
  parameter int unsigned NUM_CHANNELS = 8,
  localparam int unsigned ChanW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CHANNELS-1:0] req_i,
  input  logic                    advance_i,
  output logic [NUM_CHANNELS-1:0] grant_o,
  output logic [ChanW-1:0]        grant_idx_o,
  output logic                    valid_o
);

  localparam logic [ChanW-1:0] LastIdx = ChanW'(NUM_CHANNELS - 1);

  logic [ChanW-1:0] ptr_q;

  // First requester at or above the pointer, wrapping round
  always_comb begin
    int unsigned c;
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    c           = 0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      c = 32'(ptr_q) + i;
      if (c >= NUM_CHANNELS) c = c - NUM_CHANNELS;
      if (!valid_o && req_i[c]) begin
        valid_o     = 1'b1;
        grant_o[c]  = 1'b1;
        grant_idx_o = ChanW'(c);
      end
    end
  end

  // Pointer moves only when a grant is actually taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && valid_o) begin
      ptr_q <= (grant_idx_o == LastIdx) ? '0 : grant_idx_o + ChanW'(1);
    end
  end

endmodule

// File: rtl/spio_hss_tx_frame_mux.sv
// HSS TX framer: round-robin picks a packet stream, emits header + data words
// (+ CRC trailer when SPIO_HSS_TX_CRC_EN is defined), inserts clock-correction
// words between frames on a fixed schedule. Words advance only on TXRDY_IN.
module spio_hss_tx_frame_mux
  import spio_hss_tx_frame_mux_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned PKT_BITS     = 72,
  parameter int unsigned CC_INTERVAL  = 1000,
  parameter int unsigned CC_BITS      = 10
) (
  input  logic                             CLK_IN,
  input  logic                             RESET_IN,
  input  logic                             HANDSHAKE_COMPLETE_IN,
  input  logic [NUM_CHANNELS*PKT_BITS-1:0] TX_PKT_DATA_IN,
  input  logic [NUM_CHANNELS-1:0]          TX_PKT_VLD_IN,
  output logic [NUM_CHANNELS-1:0]          TX_PKT_RDY_OUT,
  input  logic [NUM_CHANNELS-1:0]          REMOTE_STOP_IN,
  output logic [31:0]                      TXDATA_OUT,
  output logic [3:0]                       TXCHARISK_OUT,
  input  logic                             TXRDY_IN,
  output logic [31:0]                      FRAME_COUNT_OUT
);

  localparam int unsigned Words   = (PKT_BITS + 31) / 32;
  localparam int unsigned PadBits = Words * 32;
  localparam int unsigned IdxW    = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned ChanW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [IdxW-1:0]    WordsLast = IdxW'(Words - 1);
  localparam logic [CC_BITS-1:0] CcLast    = CC_BITS'(CC_INTERVAL - 1);

  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] grant;
  logic [ChanW-1:0]        grant_idx;
  logic                    grant_vld;
  logic                    take;
  logic                    cc_pending;
  logic [PKT_BITS-1:0]     pkt_sel;

  tx_state_e               state_q;
  logic [31:0]             txdata_q;
  logic [3:0]              txk_q;
  logic [PadBits-1:0]      pkt_q;
  logic [IdxW-1:0]         word_cnt_q;
  logic [15:0]             seq_q;
  logic [31:0]             frame_cnt_q;
  logic [CC_BITS-1:0]      cc_cnt_q;
`ifdef SPIO_HSS_TX_CRC_EN
  logic [15:0]             crc_q;
`endif

  assign req        = TX_PKT_VLD_IN & ~REMOTE_STOP_IN;
  assign cc_pending = (cc_cnt_q == CcLast);

  // A packet is taken only from IDLE on a consumed word, with no CC owed
  assign take = (state_q == StIdle) && TXRDY_IN && !cc_pending && HANDSHAKE_COMPLETE_IN &&
                grant_vld && !RESET_IN;

  assign TX_PKT_RDY_OUT  = take ? grant : '0;
  assign pkt_sel         = TX_PKT_DATA_IN[int'(grant_idx) * PKT_BITS +: PKT_BITS];
  assign TXDATA_OUT      = txdata_q;
  assign TXCHARISK_OUT   = txk_q;
  assign FRAME_COUNT_OUT = frame_cnt_q;

  spio_hss_rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_arb (
    .clk_i      (CLK_IN),
    .rst_i      (RESET_IN),
    .req_i      (req),
    .advance_i  (take),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .valid_o    (grant_vld)
  );

  // CC schedule: count up, park at the last value until the CC word is consumed
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      cc_cnt_q <= '0;
    end else if (state_q == StCc && TXRDY_IN) begin
      cc_cnt_q <= '0;
    end else if (!cc_pending) begin
      cc_cnt_q <= cc_cnt_q + CC_BITS'(1);
    end
  end

  // Framer FSM: loads the next word into the output registers when the current one is consumed
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q     <= StIdle;
      txdata_q    <= IdleWord;
      txk_q       <= IdleK;
      pkt_q       <= '0;
      word_cnt_q  <= '0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
`ifdef SPIO_HSS_TX_CRC_EN
      crc_q       <= 16'hFFFF;
`endif
    end else if (TXRDY_IN) begin
      unique case (state_q)
        StIdle: begin
          if (cc_pending) begin
            state_q  <= StCc;
            txdata_q <= CcWord;
            txk_q    <= CcK;
          end else if (take) begin
            state_q  <= StHdr;
            txdata_q <= {K28_1, 8'(grant_idx), seq_q};
            txk_q    <= HdrK;
            pkt_q    <= PadBits'(pkt_sel);
          end
        end
        StCc: begin
          state_q  <= StIdle;
          txdata_q <= IdleWord;
          txk_q    <= IdleK;
        end
        StHdr: begin
          state_q    <= StData;
          txdata_q   <= pkt_q[31:0];
          txk_q      <= DataK;
          pkt_q      <= pkt_q >> 32;
          word_cnt_q <= '0;
`ifdef SPIO_HSS_TX_CRC_EN
          crc_q      <= crc16_word(16'hFFFF, pkt_q[31:0]);
`endif
        end
        StData: begin
          if (word_cnt_q != WordsLast) begin
            txdata_q   <= pkt_q[31:0];
            pkt_q      <= pkt_q >> 32;
            word_cnt_q <= word_cnt_q + IdxW'(1);
`ifdef SPIO_HSS_TX_CRC_EN
            crc_q      <= crc16_word(crc_q, pkt_q[31:0]);
`endif
          end else begin
`ifdef SPIO_HSS_TX_CRC_EN
            state_q     <= StTrl;
            txdata_q    <= {16'h0000, crc_q};
            txk_q       <= DataK;
`else
            state_q     <= StIdle;
            txdata_q    <= IdleWord;
            txk_q       <= IdleK;
            seq_q       <= seq_q + 16'd1;
            frame_cnt_q <= frame_cnt_q + 32'd1;
`endif
          end
        end
        StTrl: begin
          state_q     <= StIdle;
          txdata_q    <= IdleWord;
          txk_q       <= IdleK;
          seq_q       <= seq_q + 16'd1;
          frame_cnt_q <= frame_cnt_q + 32'd1;
        end
        default: begin
          state_q  <= StIdle;
          txdata_q <= IdleWord;
          txk_q    <= IdleK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spio_hss_tx_frame_mux.sv
// Bench for spio_hss_tx_frame_mux: word-stream model built from whole frames
// (queue of words) checked every cycle, plus literal checks on directed cases.
module tb_spio_hss_tx_frame_mux;

  localparam int N     = 8;
  localparam int PB    = 72;
  localparam int CCI   = 16;
  localparam int CCB   = 5;
  localparam int WORDS = 3;

  logic              CLK_IN = 1'b0;
  logic              RESET_IN;
  logic              hs;
  logic [N*PB-1:0]   data;
  logic [N-1:0]      vld;
  logic [N-1:0]      rdy;
  logic [N-1:0]      stop;
  logic [31:0]       txdata;
  logic [3:0]        txk;
  logic              txrdy;
  logic [31:0]       fcnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  spio_hss_tx_frame_mux #(
    .NUM_CHANNELS(N),
    .PKT_BITS    (PB),
    .CC_INTERVAL (CCI),
    .CC_BITS     (CCB)
  ) dut (
    .CLK_IN               (CLK_IN),
    .RESET_IN             (RESET_IN),
    .HANDSHAKE_COMPLETE_IN(hs),
    .TX_PKT_DATA_IN       (data),
    .TX_PKT_VLD_IN        (vld),
    .TX_PKT_RDY_OUT       (rdy),
    .REMOTE_STOP_IN       (stop),
    .TXDATA_OUT           (txdata),
    .TXCHARISK_OUT        (txk),
    .TXRDY_IN             (txrdy),
    .FRAME_COUNT_OUT      (fcnt)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr, m_cc, m_seq, m_fcnt;
  logic [31:0] m_word;
  logic [3:0]  m_k;
  bit          m_in_frame, m_is_cc;
  logic [35:0] m_q[$];

  function automatic logic [15:0] tb_crc(logic [15:0] c, logic [31:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      logic fb;
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_cc = 0; m_seq = 0; m_fcnt = 0;
    m_word = 32'hBC50_5050; m_k = 4'b1000;
    m_in_frame = 1'b0; m_is_cc = 1'b0;
    m_q.delete();
  endtask

  // Channel that must be granted right now, or -1
  function automatic int m_grant();
    if (RESET_IN || !txrdy || !hs || m_in_frame || m_is_cc || m_cc == CCI - 1) return -1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (vld[c] && !stop[c]) return c;
    end
    return -1;
  endfunction

  task automatic m_step(input int g);
    bit restart;
    logic [95:0] p;
    restart = 1'b0;
    if (txrdy) begin
      if (m_q.size() > 0) begin
        {m_k, m_word} = m_q.pop_front();
      end else if (m_in_frame) begin
        m_in_frame = 1'b0;
        m_seq  = (m_seq + 1) % 65536;
        m_fcnt = m_fcnt + 1;
        m_word = 32'hBC50_5050; m_k = 4'b1000;
      end else if (m_is_cc) begin
        m_is_cc = 1'b0;
        restart = 1'b1;
        m_word = 32'hBC50_5050; m_k = 4'b1000;
      end else if (m_cc == CCI - 1) begin
        m_is_cc = 1'b1;
        m_word = 32'hF7F7_F7F7; m_k = 4'b1111;
      end else if (g >= 0) begin
        p = '0;
        p[PB-1:0] = data[g*PB +: PB];
        m_word = {8'h3C, 8'(g), m_seq[15:0]};
        m_k = 4'b1000;
        m_in_frame = 1'b1;
        for (int w = 0; w < WORDS; w++) m_q.push_back({4'b0000, p[w*32 +: 32]});
`ifdef SPIO_HSS_TX_CRC_EN
        begin
          logic [15:0] crc;
          crc = 16'hFFFF;
          for (int w = 0; w < WORDS; w++) crc = tb_crc(crc, p[w*32 +: 32]);
          m_q.push_back({4'b0000, 16'h0000, crc});
        end
`endif
        m_ptr = (g + 1) % N;
      end
    end
    if (restart) m_cc = 0;
    else if (m_cc < CCI - 1) m_cc = m_cc + 1;
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge
  always @(negedge CLK_IN) begin
    int g;
    logic [7:0] er;
    if (RESET_IN) m_reset();
    g = m_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    if (chk_en) begin
      check("model_txdata", txdata, m_word);
      check("model_txk", 32'(txk), 32'(m_k));
      check("model_fcnt", fcnt, 32'(m_fcnt));
      check("model_rdy", 32'(rdy), 32'(er));
    end
    if (!RESET_IN) m_step(g);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N * PB / 32; i++) data[i*32 +: 32] = $urandom;
  endtask

  task automatic wait_hdr(output logic [31:0] chan);
    chan = 32'hFFFF_FFFF;
    for (int c = 0; c < 60; c++) begin
      tick();
      #1;
      if (txk == 4'b1000 && txdata[31:24] == 8'h3C) begin
        chan = 32'(txdata[23:16]);
        break;
      end
    end
  endtask

  initial begin
    logic [7:0]  chans[$];
    logic [31:0] h;
    m_reset();
    RESET_IN = 1'b1; hs = 1'b0; txrdy = 1'b0; vld = '0; stop = '0; data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    #1;
    check("reset_txdata", txdata, 32'hBC50_5050);
    check("reset_txk", 32'(txk), 32'h8);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_fcnt", fcnt, 32'h0);

    // Single ch3 packet, TXRDY held high
    tick();
    RESET_IN = 1'b0; hs = 1'b1; txrdy = 1'b1; vld = 8'h08;
    data[3*PB +: PB] = 72'h12_3456_789A_BCDE_F012;
    #1;
    check("t1_rdy", 32'(rdy), 32'h08);
    tick(); vld = '0; #1;
    check("t1_hdr", txdata, 32'h3C03_0000);
    check("t1_hdr_k", 32'(txk), 32'h8);
    tick(); #1; check("t1_d0", txdata, 32'hBCDE_F012);
    tick(); #1; check("t1_d1", txdata, 32'h3456_789A);
    tick(); #1; check("t1_d2", txdata, 32'h0000_0012);
    check("t1_d2_k", 32'(txk), 32'h0);
`ifndef SPIO_HSS_TX_CRC_EN
    tick(); #1;
    check("t1_idle", txdata, 32'hBC50_5050);
    check("t1_fcnt", fcnt, 32'h1);
`endif

    // All channels valid: rotation 0..7,0
    RESET_IN = 1'b1;
    tick();
    RESET_IN = 1'b0; rand_data(); vld = 8'hFF; stop = '0;
    for (int c = 0; c < 200 && chans.size() < 9; c++) begin
      tick();
      #1;
      if (txk == 4'b1000 && txdata[31:24] == 8'h3C) chans.push_back(txdata[23:16]);
    end
    for (int i = 0; i < 9; i++)
      check("t2_rr_chan", (i < chans.size()) ? 32'(chans[i]) : 32'hFFFF_FFFF, 32'(i % 8));

    // Remote stop on ch1: ch2 goes first, ch1 once the stop drops
    RESET_IN = 1'b1;
    tick();
    RESET_IN = 1'b0; vld = 8'h06; stop = 8'h02;
    wait_hdr(h);
    check("t3_first_chan", h, 32'h2);
    vld = 8'h02; stop = '0;
    wait_hdr(h);
    check("t3_second_chan", h, 32'h1);

    // Reset during the ch1 frame's data words
    vld = 8'h01;
    tick();
    RESET_IN = 1'b1;
    #1;
    check("t6_idle", txdata, 32'hBC50_5050);
    check("t6_k", 32'(txk), 32'h8);
    check("t6_rdy", 32'(rdy), 32'h0);
    check("t6_fcnt", fcnt, 32'h0);
    tick();
    RESET_IN = 1'b0;

    // Random traffic, back-pressure, stops, link drops and occasional resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      rand_data();
      txdata_dummy_guard();
      txrdy    = ($urandom_range(0, 2) != 0);
      vld      = 8'($urandom);
      stop     = 8'($urandom & $urandom & $urandom);
      hs       = ($urandom_range(0, 15) != 0);
      RESET_IN = ($urandom_range(0, 399) == 0);
    end
    tick();
    RESET_IN = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Keeps the random loop free of zero-delay races with the model process
  task automatic txdata_dummy_guard();
    #0;
  endtask

endmodule
